// File: rtl/sha2_pkg.sv
// Shared constants and helpers for the SHA-256 self-test: round constants,
// initial hash value, the two built-in test vectors and the sequencer states.
package sha2_pkg;

   localparam logic [0:63][31:0] K = {
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
      32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
      32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
      32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
      32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
      32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
      32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
      32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
      32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
      32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
      32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   localparam logic [0:7][31:0] IV = {
      32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
   };

   // Word 0 of each block sits in the most significant bits.
   localparam logic [511:0] BLOCK0 = {32'h61626380, 448'h0, 32'h00000018};
   localparam logic [511:0] BLOCK1 = {32'h80000000, 480'h0};

   localparam logic [255:0] EXP_DIGEST0 =
      256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
   localparam logic [255:0] EXP_DIGEST1 =
      256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_CHECK,
      ST_DONE
   } sim_state_e;

   function automatic logic [31:0] bsig0(input logic [31:0] x);
      return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
   endfunction

   function automatic logic [31:0] bsig1(input logic [31:0] x);
      return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
   endfunction

   function automatic logic [31:0] ssig0(input logic [31:0] x);
      return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
   endfunction

   function automatic logic [31:0] ssig1(input logic [31:0] x);
      return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
   endfunction

   function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y,
                                      input logic [31:0] z);
      return (x & y) ^ (~x & z);
   endfunction

   function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y,
                                       input logic [31:0] z);
      return (x & y) ^ (x & z) ^ (y & z);
   endfunction

endpackage

// File: rtl/sha2_if.sv
// Handshake between the self-test sequencer and the SHA-256 compression core.
interface sha2_if;
   logic         start;
   logic [511:0] block;
   logic         busy;
   logic         valid;
   logic [255:0] digest;

   modport master (output start, block, input busy, valid, digest);
   modport slave  (input start, block, output busy, valid, digest);
endinterface

// File: rtl/sha256_core.sv
// Single-block SHA-256 compression, one round per cycle, always from the IV.
// start is honoured only while idle; valid pulses 66 cycles after start and
// the digest is held until the next block completes.
module sha256_core
   import sha2_pkg::*;
(
   input  logic  refclk,
   input  logic  rst,
   sha2_if.slave bus
);

   logic [0:7][31:0]  wv_q;        // working variables a..h
   logic [0:15][31:0] w_q;         // sliding schedule window, w_q[0] is W[t]
   logic [6:0]        rnd_left_q;  // rounds still to run, counts 64 down to 0
   logic              busy_q;
   logic              fin_q;
   logic              valid_q;
   logic [0:7][31:0]  dig_q;

   logic [5:0]  k_idx;
   logic [31:0] t1;
   logic [31:0] t2;
   logic [31:0] w_new;

   assign bus.busy   = busy_q;
   assign bus.valid  = valid_q;
   assign bus.digest = dig_q;

   // One compression round plus the next schedule word, from current state.
   always_comb begin
      k_idx = 6'(7'd64 - rnd_left_q);
      t1    = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[k_idx] + w_q[0];
      t2    = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
      w_new = ssig1(w_q[14]) + w_q[9] + ssig0(w_q[1]) + w_q[0];
   end

   // Load on start, run 64 rounds, then fold the working set into the IV.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         wv_q       <= '0;
         w_q        <= '0;
         rnd_left_q <= '0;
         busy_q     <= 1'b0;
         fin_q      <= 1'b0;
         valid_q    <= 1'b0;
         dig_q      <= '0;
      end else begin
         valid_q <= 1'b0;
         if (!busy_q) begin
            if (bus.start) begin
               wv_q       <= IV;
               w_q        <= bus.block;
               rnd_left_q <= 7'd64;
               busy_q     <= 1'b1;
               fin_q      <= 1'b0;
            end
         end else if (!fin_q) begin
            wv_q       <= {t1 + t2, wv_q[0], wv_q[1], wv_q[2],
                           wv_q[3] + t1, wv_q[4], wv_q[5], wv_q[6]};
            w_q        <= {w_q[1:15], w_new};
            rnd_left_q <= rnd_left_q - 7'd1;
            if (rnd_left_q == 7'd1) fin_q <= 1'b1;
         end else begin
            for (int i = 0; i < 8; i++) dig_q[i] <= IV[i] + wv_q[i];
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
            fin_q   <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sha2_sim_top.sv
// SHA-256 power-on self-test: hashes "abc" and the empty message, checks both
// digests against known answers and latches done/success/report.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | one cycle after reset release
// ST_LOAD  | present block[t], pulse start to the core
// ST_RUN   | wait for core valid
// ST_CHECK | compare digest with expected set t, latch H0 into report
// ST_DONE  | terminal, results held until reset
module sha2_sim_top
   import sha2_pkg::*;
#(
   parameter bit INJECT_FAULT = 1'b0
) (
   input  logic        refclk,
   input  logic        rst,
   output logic        sim_success,
   output logic        sim_done,
   output logic [31:0] sim_report
);

   sha2_if core_bus ();

   sim_state_e   state_q;
   sim_state_e   state_d;
   logic         t_q;
   logic         pass_q;
   logic         done_q;
   logic         success_q;
   logic [31:0]  report_q;
   logic [255:0] exp_digest;
   logic         digest_ok;

   sha256_core u_core (
      .refclk (refclk),
      .rst    (rst),
      .bus    (core_bus)
   );

   assign core_bus.block = t_q ? BLOCK1 : BLOCK0;
   assign sim_done       = done_q;
   assign sim_success    = success_q;
   assign sim_report     = report_q;

   // Expected digest for the current test, with the optional planted error.
   always_comb begin
      exp_digest = t_q ? EXP_DIGEST1 : EXP_DIGEST0;
      if (INJECT_FAULT && !t_q) exp_digest[0] = ~exp_digest[0];
      digest_ok = (core_bus.digest == exp_digest);
   end

   // Sequencer state register.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Sequencer next state and core start strobe.
   always_comb begin
      state_d        = state_q;
      core_bus.start = 1'b0;
      case (state_q)
         ST_IDLE:  state_d = ST_LOAD;
         ST_LOAD: begin
            core_bus.start = 1'b1;
            state_d        = ST_RUN;
         end
         ST_RUN:   if (core_bus.valid) state_d = ST_CHECK;
         ST_CHECK: state_d = t_q ? ST_DONE : ST_LOAD;
         ST_DONE:  state_d = ST_DONE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // Test index, running pass flag and the registered status outputs.
   // The pass flag is re-armed to 1 at the first LOAD so CHECK can AND into it.
   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         t_q       <= 1'b0;
         pass_q    <= 1'b0;
         done_q    <= 1'b0;
         success_q <= 1'b0;
         report_q  <= '0;
      end else begin
         case (state_q)
            ST_LOAD: if (!t_q) pass_q <= 1'b1;
            ST_CHECK: begin
               report_q <= core_bus.digest[255:224];
               pass_q   <= pass_q & digest_ok;
               if (t_q) begin
                  done_q    <= 1'b1;
                  success_q <= pass_q & digest_ok;
               end else begin
                  t_q <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_sha2_sim_top.sv
// Bench for sha2_sim_top: a plain SHA-256 model predicts each core digest and
// the status outputs; monitors pop expectations whenever the DUT reports.
module tb_sha2_sim_top;

   logic        refclk = 1'b0;
   logic        rst    = 1'b0;
   logic        done0, succ0, done1, succ1;
   logic [31:0] rep0, rep1;

   sha2_sim_top dut0 (
      .refclk      (refclk),
      .rst         (rst),
      .sim_success (succ0),
      .sim_done    (done0),
      .sim_report  (rep0)
   );

   sha2_sim_top #(.INJECT_FAULT(1'b1)) dut1 (
      .refclk      (refclk),
      .rst         (rst),
      .sim_success (succ1),
      .sim_done    (done1),
      .sim_report  (rep1)
   );

   sha2_if probe ();
   assign probe.start  = dut0.core_bus.start;
   assign probe.block  = dut0.core_bus.block;
   assign probe.busy   = dut0.core_bus.busy;
   assign probe.valid  = dut0.core_bus.valid;
   assign probe.digest = dut0.core_bus.digest;

   always #42 refclk = ~refclk;

   localparam logic [31:0] MK [64] = '{
      32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1,
      32'h923f82a4, 32'hab1c5ed5, 32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
      32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174, 32'he49b69c1, 32'hefbe4786,
      32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
      32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147,
      32'h06ca6351, 32'h14292967, 32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
      32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85, 32'ha2bfe8a1, 32'ha81a664b,
      32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
      32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a,
      32'h5b9cca4f, 32'h682e6ff3, 32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
      32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
   };

   typedef struct {
      logic        success;
      logic [31:0] report;
   } final_t;

   int           checks = 0;
   int           errors = 0;
   logic [255:0] exp_dig0, exp_dig1;
   logic [255:0] dig_q [$];
   logic [31:0]  rep_q [$];
   final_t       fin0_q [$];
   final_t       fin1_q [$];

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      checks++;
      errors++;
      $display("FAIL %s: DUT reported with nothing expected", name);
   endtask

   function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
      return (x >> n) | (x << (32 - n));
   endfunction

   // Standard padding of a short message into one 512-bit block.
   function automatic logic [511:0] pad_msg(input string s);
      logic [511:0] blk = '0;
      int len = s.len();
      for (int i = 0; i < len; i++) blk[511 - 8*i -: 8] = s[i];
      blk[511 - 8*len -: 8] = 8'h80;
      blk[63:0] = 64'(len * 8);
      return blk;
   endfunction

   // Textbook SHA-256 of one block with a fully expanded schedule.
   function automatic logic [255:0] sha256_model(input logic [511:0] blk);
      logic [31:0] w [64];
      logic [31:0] h [8];
      logic [31:0] a, b, c, d, e, f, g, hh, s0, s1, t1, t2;
      h = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
            32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
      for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
      for (int t = 16; t < 64; t++) begin
         s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
         s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
         w[t] = w[t-16] + s0 + w[t-7] + s1;
      end
      a = h[0]; b = h[1]; c = h[2]; d = h[3];
      e = h[4]; f = h[5]; g = h[6]; hh = h[7];
      for (int t = 0; t < 64; t++) begin
         t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + MK[t] + w[t];
         t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
         hh = g; g = f; f = e; e = d + t1;
         d = c; c = b; b = a; a = t1 + t2;
      end
      return {h[0] + a, h[1] + b, h[2] + c, h[3] + d,
              h[4] + e, h[5] + f, h[6] + g, h[7] + hh};
   endfunction

   task automatic push_run(input bit full);
      final_t f;
      dig_q.push_back(exp_dig0);
      rep_q.push_back(exp_dig0[255:224]);
      if (full) begin
         dig_q.push_back(exp_dig1);
         rep_q.push_back(exp_dig1[255:224]);
         f.success = 1'b1; f.report = exp_dig1[255:224];
         fin0_q.push_back(f);
         f.success = 1'b0;
         fin1_q.push_back(f);
      end
   endtask

   task automatic check_idle(input string tag);
      check({tag, "_outputs_dut0"}, {done0, succ0, rep0}, '0);
      check({tag, "_outputs_dut1"}, {done1, succ1, rep1}, '0);
   endtask

   task automatic wait_valid(input int bound, output int took, output bit seen);
      took = 0;
      seen = 1'b0;
      while (took < bound && !seen) begin
         @(negedge refclk);
         took++;
         if (probe.valid) seen = 1'b1;
      end
   endtask

   task automatic wait_done(input int bound);
      int n = 0;
      while (n < bound && !(done0 && done1)) begin
         @(negedge refclk);
         n++;
      end
   endtask

   // Monitor: pops expectations on core valid, report updates and done rising.
   int          cyc = 0;
   int          start_cyc = 0;
   logic        prev_done0 = 1'b0, prev_done1 = 1'b0;
   logic [31:0] prev_rep0 = '0;
   always @(negedge refclk) begin
      final_t f;
      cyc++;
      if (probe.start) start_cyc = cyc;
      if (probe.valid) begin
         if (dig_q.size() == 0) unexpected("core_digest");
         else check("core_digest", probe.digest, dig_q.pop_front());
         check("core_latency", 256'(cyc - start_cyc), 256'(66));
      end
      if (rep0 != prev_rep0 && rep0 != 32'h0) begin
         if (rep_q.size() == 0) unexpected("report_update");
         else check("report_update", rep0, rep_q.pop_front());
      end
      if (done0 && !prev_done0) begin
         if (fin0_q.size() == 0) unexpected("final_dut0");
         else begin
            f = fin0_q.pop_front();
            check("final_dut0", {succ0, rep0}, {f.success, f.report});
         end
      end
      if (done1 && !prev_done1) begin
         if (fin1_q.size() == 0) unexpected("final_dut1");
         else begin
            f = fin1_q.pop_front();
            check("final_dut1", {succ1, rep1}, {f.success, f.report});
         end
      end
      prev_done0 = done0;
      prev_done1 = done1;
      prev_rep0  = rep0;
   end

   // Stimulus: reset, full run, long hold, mid-run abort, rerun.
   initial begin
      int          took;
      int          changes;
      bit          seen;
      logic [67:0] snap;
      exp_dig0 = sha256_model(pad_msg("abc"));
      exp_dig1 = sha256_model(pad_msg(""));

      rst = 1'b0;
      repeat ($urandom_range(10, 20)) @(negedge refclk);
      check_idle("reset");
      push_run(1'b1);
      rst = 1'b1;
      wait_valid(80, took, seen);
      check("first_valid_seen", seen, 1'b1);
      check("report_before_check", rep0, '0);
      wait_done(150 - took);
      check("done_within_150", {done0, done1}, 2'b11);

      snap = {done0, succ0, rep0, done1, succ1, rep1};
      changes = 0;
      repeat (10000) begin
         @(negedge refclk);
         if ({done0, succ0, rep0, done1, succ1, rep1} != snap) changes++;
      end
      check("hold_stable_changes", 256'(changes), '0);
      check("hold_values_dut0", {done0, succ0, rep0}, {2'b11, exp_dig1[255:224]});

      rst = 1'b0;
      #1;
      check_idle("reassert");
      repeat ($urandom_range(3, 8)) @(negedge refclk);
      push_run(1'b0);
      rst = 1'b1;
      wait_valid(80, took, seen);
      check("abort_run_first_valid", seen, 1'b1);
      repeat ($urandom_range(5, 60)) @(negedge refclk);
      check("abort_core_busy", probe.busy, 1'b1);
      rst = 1'b0;
      #1;
      check_idle("abort");
      check("abort_core_idle", {probe.busy, probe.valid}, 2'b00);
      repeat ($urandom_range(3, 8)) @(negedge refclk);
      push_run(1'b1);
      rst = 1'b1;
      wait_valid(80, took, seen);
      check("rerun_first_valid", seen, 1'b1);
      check("rerun_report_before_check", rep0, '0);
      wait_done(150 - took);
      check("rerun_done_dut0", {done0, succ0, rep0}, {2'b11, exp_dig1[255:224]});
      check("rerun_done_dut1", {done1, succ1, rep1}, {2'b10, exp_dig1[255:224]});
      repeat (3) @(negedge refclk);
      check("scoreboard_drained",
            256'(dig_q.size() + rep_q.size() + fin0_q.size() + fin1_q.size()), '0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Hard stop in case something above never returns.
   initial begin
      repeat (60000) @(posedge refclk);
      $display("FAIL watchdog: bench still running after 60000 cycles, expected to have finished");
      $fatal(1, "watchdog expired");
   end

endmodule
